instr_fetch_mem: RTL and testbench



---
 rtl/instr_fetch_mem.sv | 120 ++++++++++++
 tb/tb_instr_fetch_mem.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// ============================================================================
// Module   : instr_fetch_mem
// Brief    : Parametrised instruction memory with registered fetch, stall,
//            flush, runtime program-load port and saturating fetch counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_mem #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 1024,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h41E00000,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_instr;
    logic                r_fault;
    logic [CNT_W-1:0]    r_fetch_cnt;

    // Power-up contents are the pipeline NOP; reset never touches the array.
    logic [DATA_W-1:0]   r_mem [DEPTH] = '{default: NOP_WORD};

    logic                w_fetch_in_range;
    logic                w_load_in_range;
    logic [c_IDX_W-1:0]  w_fetch_idx;
    logic [c_IDX_W-1:0]  w_load_idx;
    logic                w_bypass;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_cnt_full;

    generate
        if (DEPTH >= (2 ** ADDR_W)) begin : g_full_range
            assign w_fetch_in_range = 1'b1;
            assign w_load_in_range  = 1'b1;
        end else begin : g_partial_range
            localparam logic [ADDR_W-1:0] c_DEPTH_A = ADDR_W'(DEPTH);
            assign w_fetch_in_range = (fetch_addr < c_DEPTH_A);
            assign w_load_in_range  = (load_addr < c_DEPTH_A);
        end
    endgenerate

    assign w_fetch_idx = fetch_addr[c_IDX_W-1:0];
    assign w_load_idx  = load_addr[c_IDX_W-1:0];

    // Write-first: a same-cycle load to the fetched word is forwarded.
    assign w_bypass  = load_en && w_load_in_range && (load_addr == fetch_addr);
    assign w_rd_data = w_bypass ? load_data : r_mem[w_fetch_idx];

    assign w_cnt_full = &r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (load_en && w_load_in_range) begin
            r_mem[w_load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_instr     <= NOP_WORD;
            r_fault     <= 1'b0;
            r_fetch_cnt <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_instr <= NOP_WORD;
            r_fault <= 1'b0;
        end else if (stall) begin
            r_state <= r_state;
            r_instr <= r_instr;
            r_fault <= r_fault;
        end else if (fetch_req) begin
            r_state <= ST_VALID;
            if (w_fetch_in_range) begin
                r_instr <= w_rd_data;
                r_fault <= 1'b0;
            end else begin
                r_instr <= NOP_WORD;
                r_fault <= 1'b1;
            end
            if (!w_cnt_full) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
        end else begin
            r_state <= ST_IDLE;
            r_instr <= NOP_WORD;
            r_fault <= 1'b0;
        end
    end

    assign instr       = r_instr;
    assign instr_valid = (r_state == ST_VALID);
    assign addr_fault  = r_fault;
    assign fetch_cnt   = r_fetch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
// ============================================================================
// Module   : tb_instr_fetch_mem
// Brief    : Self-checking bench for instr_fetch_mem (full-size and
//            512-word / 4-bit-counter instances driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_mem;

    localparam logic [31:0] NOP = 32'h41E00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [9:0]  fetch_addr = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        load_en = 1'b0;
    logic [9:0]  load_addr = '0;
    logic [31:0] load_data = '0;

    logic [31:0] instr_a, instr_b;
    logic        valid_a, valid_b, fault_a, fault_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    instr_fetch_mem dut_a (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .stall(stall), .flush(flush), .instr(instr_a), .instr_valid(valid_a),
        .addr_fault(fault_a), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .fetch_cnt(cnt_a)
    );

    instr_fetch_mem #(.DEPTH(512), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .stall(stall), .flush(flush), .instr(instr_b), .instr_valid(valid_b),
        .addr_fault(fault_b), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .fetch_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 = full-size instance, index 1 = small instance.
    int          dep  [2] = '{1024, 512};
    int          cmax [2] = '{65535, 15};
    logic [31:0] mem  [2][1024];
    logic [31:0] e_instr [2];
    logic        e_valid [2];
    logic        e_fault [2];
    int          e_cnt   [2];

    int checks = 0;
    int failures = 0;

    function automatic logic [49:0] exp_a();
        logic [15:0] c;
        c = e_cnt[0][15:0];
        return {e_instr[0], e_valid[0], e_fault[0], c};
    endfunction

    function automatic logic [37:0] exp_b();
        logic [3:0] c;
        c = e_cnt[1][3:0];
        return {e_instr[1], e_valid[1], e_fault[1], c};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_instr[k] = NOP;
            e_valid[k] = 1'b0;
            e_fault[k] = 1'b0;
            e_cnt[k]   = 0;
        end
    endtask

    // Applies the spec's rules for the upcoming edge, then advances the clock.
    task automatic cycle();
        for (int k = 0; k < 2; k++) begin
            if (load_en && int'(load_addr) < dep[k]) mem[k][load_addr] = load_data;
            if (!rst_n) begin
                e_instr[k] = NOP; e_valid[k] = 1'b0; e_fault[k] = 1'b0; e_cnt[k] = 0;
            end else if (flush) begin
                e_instr[k] = NOP; e_valid[k] = 1'b0; e_fault[k] = 1'b0;
            end else if (stall) begin
                // outputs hold
            end else if (fetch_req) begin
                e_valid[k] = 1'b1;
                if (int'(fetch_addr) < dep[k]) begin
                    e_instr[k] = mem[k][fetch_addr];
                    e_fault[k] = 1'b0;
                end else begin
                    e_instr[k] = NOP;
                    e_fault[k] = 1'b1;
                end
                if (e_cnt[k] < cmax[k]) e_cnt[k] = e_cnt[k] + 1;
            end else begin
                e_instr[k] = NOP; e_valid[k] = 1'b0; e_fault[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input int addr, input logic st, input logic fl,
                         input logic le, input int la, input logic [31:0] ld);
        fetch_req  = req;
        fetch_addr = 10'(addr);
        stall      = st;
        flush      = fl;
        load_en    = le;
        load_addr  = 10'(la);
        load_data  = ld;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        cycle();
        cycle();
        checks++;
        if ({instr_a, valid_a, fault_a, cnt_a} !== {NOP, 1'b0, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL reset_hold_a got=%h exp=%h", {instr_a, valid_a, fault_a, cnt_a}, {NOP, 2'b00, 16'd0});
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if ({instr_a, valid_a, fault_a, cnt_a} !== exp_a() || {instr_b, valid_b, fault_b, cnt_b} !== exp_b()) begin
            failures++;
            $display("FAIL reset_idle got_a=%h exp_a=%h got_b=%h exp_b=%h",
                     {instr_a, valid_a, fault_a, cnt_a}, exp_a(), {instr_b, valid_b, fault_b, cnt_b}, exp_b());
        end
    endtask

    task automatic test_load_fetch();
        int seq [3] = '{0, 5, 0};
        drive(0, 0, 0, 0, 1, 5, 32'h3C0A1932);
        cycle();
        drive(1, 5, 0, 0, 0, 0, 0);
        cycle();
        checks++;
        if (instr_a !== 32'h3C0A1932 || valid_a !== 1'b1 || cnt_a !== 16'd1 || instr_b !== 32'h3C0A1932) begin
            failures++;
            $display("FAIL load_fetch got_a=%h/%b/%0d got_b=%h exp=3c0a1932/1/1",
                     instr_a, valid_a, cnt_a, instr_b);
        end
        foreach (seq[i]) begin
            drive(1, seq[i], 0, 0, 0, 0, 0);
            cycle();
            checks++;
            if ({instr_a, valid_a, fault_a, cnt_a} !== exp_a() || {instr_b, valid_b, fault_b, cnt_b} !== exp_b()) begin
                failures++;
                $display("FAIL back_to_back[%0d] got_a=%h exp_a=%h got_b=%h exp_b=%h", i,
                         {instr_a, valid_a, fault_a, cnt_a}, exp_a(), {instr_b, valid_b, fault_b, cnt_b}, exp_b());
            end
        end
    endtask

    task automatic test_stall_flush();
        logic [15:0] cnt_before;
        drive(1, 5, 0, 0, 0, 0, 0);
        cycle();
        cnt_before = cnt_a;
        for (int i = 0; i < 3; i++) begin
            drive(1, 7, 1, 0, 0, 0, 0);
            cycle();
            checks++;
            if (instr_a !== 32'h3C0A1932 || valid_a !== 1'b1 || cnt_a !== cnt_before ||
                {instr_b, valid_b, fault_b, cnt_b} !== exp_b()) begin
                failures++;
                $display("FAIL stall_hold[%0d] got_a=%h/%b/%0d exp_a=3c0a1932/1/%0d got_b=%h exp_b=%h", i,
                         instr_a, valid_a, cnt_a, cnt_before, {instr_b, valid_b, fault_b, cnt_b}, exp_b());
            end
        end
        drive(1, 7, 1, 1, 0, 0, 0);
        cycle();
        checks++;
        if (instr_a !== NOP || valid_a !== 1'b0 || fault_a !== 1'b0 || cnt_a !== cnt_before ||
            {instr_b, valid_b, fault_b, cnt_b} !== exp_b()) begin
            failures++;
            $display("FAIL flush_over_stall got_a=%h/%b/%0d exp_a=%h/0/%0d", instr_a, valid_a, cnt_a, NOP, cnt_before);
        end
    endtask

    task automatic test_bypass();
        drive(1, 9, 0, 0, 1, 9, 32'hDEADBEEF);
        cycle();
        checks++;
        if (instr_a !== 32'hDEADBEEF || instr_b !== 32'hDEADBEEF || valid_a !== 1'b1) begin
            failures++;
            $display("FAIL bypass got_a=%h got_b=%h exp=deadbeef", instr_a, instr_b);
        end
        drive(1, 9, 0, 0, 0, 0, 0);
        cycle();
        checks++;
        if (instr_a !== 32'hDEADBEEF || {instr_b, valid_b, fault_b, cnt_b} !== exp_b()) begin
            failures++;
            $display("FAIL bypass_stored got_a=%h exp_a=deadbeef got_b=%h exp_b=%h",
                     instr_a, {instr_b, valid_b, fault_b, cnt_b}, exp_b());
        end
    endtask

    task automatic test_out_of_range();
        int addrs [5] = '{600, 511, 512, 1023, 88};
        logic [3:0] cb;
        cb = cnt_b;
        drive(1, 600, 0, 0, 0, 0, 0);
        cycle();
        checks++;
        if (instr_b !== NOP || valid_b !== 1'b1 || fault_b !== 1'b1 ||
            cnt_b !== ((cb == 4'hF) ? 4'hF : cb + 4'd1) || fault_a !== 1'b0) begin
            failures++;
            $display("FAIL oor_fetch got_b=%h/%b/%b/%0d exp_b=%h/1/1 fault_a=%b", instr_b, valid_b, fault_b, cnt_b, NOP, fault_a);
        end
        drive(0, 0, 0, 0, 1, 600, 32'hCAFEF00D);
        cycle();
        drive(0, 0, 0, 0, 1, 511, 32'h12345678);
        cycle();
        foreach (addrs[i]) begin
            drive(1, addrs[i], 0, 0, 0, 0, 0);
            cycle();
            checks++;
            if ({instr_a, valid_a, fault_a, cnt_a} !== exp_a() || {instr_b, valid_b, fault_b, cnt_b} !== exp_b()) begin
                failures++;
                $display("FAIL oor_boundary[%0d] got_a=%h exp_a=%h got_b=%h exp_b=%h", addrs[i],
                         {instr_a, valid_a, fault_a, cnt_a}, exp_a(), {instr_b, valid_b, fault_b, cnt_b}, exp_b());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int fa, la;
            fa = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1023));
            la = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) la = fa;
            drive($urandom_range(0, 3) != 0, fa, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, la, $urandom);
            cycle();
            checks++;
            if ({instr_a, valid_a, fault_a, cnt_a} !== exp_a() || {instr_b, valid_b, fault_b, cnt_b} !== exp_b()) begin
                failures++;
                $display("FAIL random[%0d] got_a=%h exp_a=%h got_b=%h exp_b=%h", i,
                         {instr_a, valid_a, fault_a, cnt_a}, exp_a(), {instr_b, valid_b, fault_b, cnt_b}, exp_b());
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive(1, int'($urandom_range(0, 1023)), 0, 0, 0, 0, 0);
            cycle();
            checks++;
            if ({instr_a, valid_a, fault_a, cnt_a} !== exp_a() || {instr_b, valid_b, fault_b, cnt_b} !== exp_b()) begin
                failures++;
                $display("FAIL saturation[%0d] got_a=%h exp_a=%h got_b=%h exp_b=%h", i,
                         {instr_a, valid_a, fault_a, cnt_a}, exp_a(), {instr_b, valid_b, fault_b, cnt_b}, exp_b());
            end
        end
        checks++;
        if (cnt_b !== 4'd15) begin
            failures++;
            $display("FAIL saturation_final got=%0d exp=15", cnt_b);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 0, 0, 1, 5, 32'h3C0A1932);
        cycle();
        drive(1, 5, 0, 0, 0, 0, 0);
        cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({instr_a, valid_a, fault_a, cnt_a} !== {NOP, 2'b00, 16'd0} ||
            {instr_b, valid_b, fault_b, cnt_b} !== {NOP, 2'b00, 4'd0}) begin
            failures++;
            $display("FAIL async_reset got_a=%h got_b=%h exp=%h", {instr_a, valid_a, fault_a, cnt_a},
                     {instr_b, valid_b, fault_b, cnt_b}, NOP);
        end
        cycle();
        rst_n = 1'b1;
        drive(1, 5, 0, 0, 0, 0, 0);
        cycle();
        checks++;
        if (instr_a !== 32'h3C0A1932 || instr_b !== 32'h3C0A1932 || cnt_a !== 16'd1 || cnt_b !== 4'd1 ||
            {instr_a, valid_a, fault_a, cnt_a} !== exp_a()) begin
            failures++;
            $display("FAIL mem_retained got_a=%h/%0d got_b=%h/%0d exp=3c0a1932/1", instr_a, cnt_a, instr_b, cnt_b);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 1024; a++) mem[k][a] = NOP;
        model_reset();
        test_reset();
        test_load_fetch();
        test_stall_flush();
        test_bypass();
        test_out_of_range();
        test_random();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
